// File: rtl/freqdiv_multi.sv
// Multi-channel programmable clock-enable divider: per-channel square wave plus
// end-of-period tick, with shadowed divisor updates and a shared phase realign.
module freqdiv_multi #(
  parameter int CHANNELS    = 3,
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         sync,
  input  logic [CHANNELS-1:0]          div_load,
  input  logic [CHANNELS*WIDTH-1:0]    div_value,
  output logic [CHANNELS-1:0]          clk_out,
  output logic [CHANNELS-1:0]          tick
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
  localparam logic [WIDTH:0]   ONE_W   = (WIDTH+1)'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic [WIDTH-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] next_div;
    logic [WIDTH:0]   half_up;
    logic             active;
    logic             wrap;

    // A load on the same edge as a commit bypasses the shadow register.
    assign next_div = div_load[i] ? div_value[i*WIDTH +: WIDTH] : shd_q;
    assign half_up  = ({1'b0, act_q} + ONE_W) >> 1;
    assign active   = (act_q >= TWO);
    assign wrap     = (cnt_q == (act_q - ONE));

    always_comb begin
      cnt_d     = cnt_q;
      act_d     = act_q;
      shd_d     = next_div;
      pend_d    = pend_q | div_load[i];
      clk_out_d = clk_out_q;
      tick_d    = 1'b0;
      if (sync || !active) begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        if (pend_d) begin
          act_d  = next_div;
          pend_d = 1'b0;
        end
      end else if (enable) begin
        clk_out_d = ({1'b0, cnt_q} < half_up);
        tick_d    = wrap;
        if (wrap) begin
          cnt_d = '0;
          if (pend_d) begin
            act_d  = next_div;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q     <= '0;
        act_q     <= DIV_RST;
        shd_q     <= DIV_RST;
        pend_q    <= 1'b0;
        clk_out_q <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        act_q     <= act_d;
        shd_q     <= shd_d;
        pend_q    <= pend_d;
        clk_out_q <= clk_out_d;
        tick_q    <= tick_d;
      end
    end

    assign clk_out[i] = clk_out_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_freqdiv_multi.sv
// Scoreboard bench for freqdiv_multi: stimulus queues per-cycle expected
// clk_out/tick patterns, a negedge monitor pops and compares them.
module tb_freqdiv_multi;

  localparam int CH = 3;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            sync;
  logic [CH-1:0]   div_load;
  logic [CH*W-1:0] div_value;
  logic [CH-1:0]   clk_out;
  logic [CH-1:0]   tick;

  freqdiv_multi #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .sync      (sync),
    .div_load  (div_load),
    .div_value (div_value),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [2:0]  c;
    logic [2:0]  t;
    logic [2:0]  cm;
    logic [2:0]  tm;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Strings list one char per cycle: '1'/'0' expected, '.' or past end = don't care.
  task automatic push_seq(input string name, input int start,
                          input string c0, input string t0,
                          input string c1, input string t1,
                          input string c2, input string t2);
    string cs[3];
    string ts[3];
    int    n;
    exp_t  e;
    cs[0] = c0; cs[1] = c1; cs[2] = c2;
    ts[0] = t0; ts[1] = t1; ts[2] = t2;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      if (cs[k].len() > n) n = cs[k].len();
      if (ts[k].len() > n) n = ts[k].len();
    end
    for (int i = 0; i < n; i++) begin
      e.cyc  = start + i;
      e.name = name;
      for (int k = 0; k < 3; k++) begin
        e.cm[k] = (i < cs[k].len()) && (cs[k].getc(i) != ".");
        e.c[k]  = (i < cs[k].len()) && (cs[k].getc(i) == "1");
        e.tm[k] = (i < ts[k].len()) && (ts[k].getc(i) != ".");
        e.t[k]  = (i < ts[k].len()) && (ts[k].getc(i) == "1");
      end
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (mon_e.cyc < cyc) begin
        errors++;
        $display("FAIL %s missed: expected at cycle %0d, monitor at %0d", mon_e.name, mon_e.cyc, cyc);
      end else if (((clk_out & mon_e.cm) !== (mon_e.c & mon_e.cm)) ||
                   ((tick & mon_e.tm) !== (mon_e.t & mon_e.tm))) begin
        errors++;
        $display("FAIL %s cycle %0d: clk_out=%b tick=%b, required clk_out=%b tick=%b (masks %b/%b)",
                 mon_e.name, cyc, clk_out, tick, mon_e.c, mon_e.t, mon_e.cm, mon_e.tm);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    sync      = 1'b0;
    div_load  = '0;
    div_value = '0;

    step(1);
    push_seq("reset", cyc + 1, "00", "00", "00", "00", "00", "00");
    step(3);
    reset = 1'b1;

    // Test 1: load 2/3/4 while frozen, sync, then free-run.
    div_value = {8'd4, 8'd3, 8'd2};
    div_load  = 3'b111;
    push_seq("t1_load", cyc + 1, "0", "0", "0", "0", "0", "0");
    step(1);
    div_load = '0;
    sync     = 1'b1;
    enable   = 1'b1;
    push_seq("t1_sync", cyc + 1, "0", "0", "0", "0", "0", "0");
    step(1);
    sync = 1'b0;
    push_seq("t1_run", cyc + 1,
             "101010101010", "010101010101",
             "110110110110", "001001001001",
             "110011001100", "000100010001");
    step(12);

    // Test 2: ch1 to 5, then 3 loaded mid-period.
    div_value[15:8] = 8'd5;
    div_load        = 3'b010;
    push_seq("t2_switch", cyc + 1, "", "", "11011100110110", "00100001001001", "", "");
    step(1);
    div_load = '0;
    step(3);
    div_value[15:8] = 8'd3;
    div_load        = 3'b010;
    step(1);
    div_load = '0;
    step(9);

    // Test 3: ch0 through divisors 0 and 1 (idle), then 4.
    div_value[7:0] = 8'd0;
    div_load       = 3'b001;
    push_seq("t3_idle", cyc + 1, "100000011001", "010000000010", "", "", "", "");
    step(1);
    div_load = '0;
    step(2);
    div_value[7:0] = 8'd1;
    div_load       = 3'b001;
    step(1);
    div_load = '0;
    step(2);
    div_value[7:0] = 8'd4;
    div_load       = 3'b001;
    step(1);
    div_load = '0;
    step(5);

    // Test 4: freeze 7 cycles mid-period with ch0 high at cnt=1.
    enable = 1'b0;
    push_seq("t4_freeze", cyc + 1, "111111110011", "000000000100", "", "0000000", "", "0000000");
    step(7);
    enable = 1'b1;
    step(5);

    // Test 5: sync realign with ch0=4, ch1=3, plus load 5 on ch2 at the same edge.
    sync            = 1'b1;
    div_value[23:16] = 8'd5;
    div_load        = 3'b100;
    push_seq("t5_sync", cyc + 1,
             "01100110011", "00001000100",
             "01101101101", "00010010010",
             "01110011100", "00000100001");
    step(1);
    sync     = 1'b0;
    div_load = '0;
    step(10);

    // Test 6: ch2 at 255, async reset mid-high-phase, recovery at default 2.
    div_value[23:16] = 8'd255;
    div_load         = 3'b100;
    sync             = 1'b1;
    push_seq("t6_run255", cyc + 1, "0", "0", "0", "0",
             "01111111111111111111", "00000000000000000000");
    push_seq("t6_async", cyc + 21, "0", "0", "0", "0", "0", "0");
    step(1);
    sync     = 1'b0;
    div_load = '0;
    step(20);
    #3;
    reset = 1'b0;
    push_seq("t6_hold", cyc + 1, "00", "00", "00", "00", "00", "00");
    step(2);
    reset = 1'b1;
    push_seq("t6_default", cyc + 1,
             "101010", "010101", "101010", "010101", "101010", "010101");
    step(6);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) step(1);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never compared, required 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
